// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline WB stage
// and a small FIFO of results from the multicycle (AES/SIMD) unit.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data  pipeline write request (held while pipe_stall=1)
//   mc_valid/mc_rd/mc_data  multicycle result, accepted when mc_ready=1
//   mc_ready                queue not full
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   pipe_stall              queue head is being forced; pipeline must hold WB
//
// Arbitration: a starved queue head (starve_cnt at STARVE_LIMIT) wins and
// stalls the pipeline; otherwise the pipeline wins, and the queue drains on
// idle WB cycles. A freshly pushed head waits one cycle before it can be
// granted, so a result never reaches rf_we earlier than two edges after it
// was accepted.
module wb_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  input  logic [4:0]        mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pipe_stall
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  logic [4:0]        q_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;
  // Head entry was written on the most recent edge and is not yet eligible.
  logic              head_fresh;

  logic              q_empty;
  logic              q_full;
  logic              head_ok;
  logic              force_q;
  logic              grant_wb;
  logic              pop;
  logic              push;
  logic              grant;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  count_next;
  logic [STV_W-1:0]  starve_next;

  always_comb begin
    q_empty  = (count == '0);
    q_full   = (count == FULL_CNT);
    head_ok  = !q_empty && !head_fresh;
    force_q  = head_ok && (starve_cnt == STV_MAX);
    grant_wb = wb_valid && !force_q;
    pop      = force_q || (!wb_valid && head_ok);
    push     = mc_valid && !q_full;
    grant    = pop || grant_wb;

    sel_rd   = wb_rd;
    sel_data = wb_data;
    if (pop) begin
      sel_rd   = q_rd[rd_ptr];
      sel_data = q_data[rd_ptr];
    end

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + ONE_CNT;
      2'b01:   count_next = count - ONE_CNT;
      default: count_next = count;
    endcase

    starve_next = starve_cnt;
    if (pop || q_empty) begin
      starve_next = '0;
    end else if (starve_cnt != STV_MAX) begin
      starve_next = starve_cnt + STV_ONE;
    end
  end

  assign mc_ready   = !q_full;
  assign pipe_stall = force_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      head_fresh <= 1'b0;
    end else begin
      if (push) begin
        q_rd[wr_ptr]   <= mc_rd;
        q_data[wr_ptr] <= mc_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_next;
      starve_cnt <= starve_next;
      // Only the entry just pushed can be the head when exactly one remains.
      head_fresh <= push && (count_next == ONE_CNT);
    end
  end

  // Register-zero writes are consumed but never reach the register file;
  // address and data hold their last written values otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant && (sel_rd != 5'd0);
      if (grant && (sel_rd != 5'd0)) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Randomized and directed stimulus for wb_port_arbiter, checked every cycle
// against a queue-based reference model, plus literal expectations for the
// basic write, latency, starvation, register-zero, push/pop and reset cases.
module tb_wb_port_arbiter;
  localparam int DATA_W       = 64;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 3;

  logic              clk;
  logic              rst_n;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid;
  logic [4:0]        mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pipe_stall;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: queue entries remember the edge at which they were
  // accepted; an entry may only be granted once a later edge has passed.
  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    int                edge_no;
  } ent_t;

  ent_t              q[$];
  int                starve;
  int                edge_cnt;
  bit                chk_en;
  logic              exp_we;
  logic [4:0]        exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_stall;
  logic              exp_ready;

  function automatic bit head_eligible();
    return (q.size() > 0) && (q[0].edge_no < edge_cnt);
  endfunction

  task automatic model_reset();
    q.delete();
    starve    = 0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_stall = 1'b0;
    exp_ready = 1'b1;
  endtask

  // One clock: decide from model state and the inputs now on the pins, wait
  // for the edge, then commit the model.
  task automatic step();
    bit                forced, pop, gwb, push, wr;
    logic [4:0]        srd;
    logic [DATA_W-1:0] sdata;
    logic [4:0]        prd;
    logic [DATA_W-1:0] pdata;
    int                starve_n;
    forced = head_eligible() && (starve == STARVE_LIMIT);
    pop = 1'b0;
    gwb = 1'b0;
    if (forced) pop = 1'b1;
    else if (wb_valid) gwb = 1'b1;
    else if (head_eligible()) pop = 1'b1;
    push  = mc_valid && (q.size() < FIFO_DEPTH);
    prd   = mc_rd;
    pdata = mc_data;
    srd   = pop ? q[0].rd : wb_rd;
    sdata = pop ? q[0].data : wb_data;
    wr    = (pop || gwb) && (srd != 5'd0);
    if (pop || q.size() == 0) starve_n = 0;
    else starve_n = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
    @(posedge clk);
    edge_cnt++;
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{rd: prd, data: pdata, edge_no: edge_cnt});
    starve = starve_n;
    exp_we = wr;
    if (wr) begin
      exp_addr = srd;
      exp_data = sdata;
    end
    exp_stall = head_eligible() && (starve == STARVE_LIMIT);
    exp_ready = (q.size() < FIFO_DEPTH);
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cmp_rf_we", 64'(rf_we), 64'(exp_we));
      check("cmp_rf_waddr", 64'(rf_waddr), 64'(exp_addr));
      check("cmp_rf_wdata", rf_wdata, exp_data);
      check("cmp_mc_ready", 64'(mc_ready), 64'(exp_ready));
      check("cmp_pipe_stall", 64'(pipe_stall), 64'(exp_stall));
    end
  end

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [DATA_W-1:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_mc(input logic v, input logic [4:0] rd, input logic [DATA_W-1:0] d);
    mc_valid = v; mc_rd = rd; mc_data = d;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    check("rst_mc_ready", 64'(mc_ready), 64'd1);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    chk_en   = 1'b0;
    edge_cnt = 0;
    rst_n    = 1'b0;
    set_wb(1'b0, 5'd0, '0);
    set_mc(1'b0, 5'd0, '0);
    model_reset();
    #12;
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset_rf_wdata", rf_wdata, 64'd0);
    check("reset_mc_ready", 64'(mc_ready), 64'd1);
    check("reset_pipe_stall", 64'(pipe_stall), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Lone pipeline write
    set_wb(1'b1, 5'd5, 64'hA5);
    step();
    check("wb_lone_we", 64'(rf_we), 64'd1);
    check("wb_lone_addr", 64'(rf_waddr), 64'd5);
    check("wb_lone_data", rf_wdata, 64'hA5);
    set_wb(1'b0, 5'd0, '0);
    step();
    check("wb_lone_we_after", 64'(rf_we), 64'd0);

    // Lone multicycle write: visible after the second edge past acceptance
    set_mc(1'b1, 5'd7, 64'h1234);
    step();
    check("mc_lone_ready", 64'(mc_ready), 64'd1);
    check("mc_lone_we_n0", 64'(rf_we), 64'd0);
    set_mc(1'b0, 5'd0, '0);
    step();
    check("mc_lone_we_n1", 64'(rf_we), 64'd0);
    step();
    check("mc_lone_we_n2", 64'(rf_we), 64'd1);
    check("mc_lone_addr", 64'(rf_waddr), 64'd7);
    check("mc_lone_data", rf_wdata, 64'h1234);

    // Queue fill and starvation under continuous pipeline writes
    set_wb(1'b1, 5'd10, 64'h10);
    set_mc(1'b1, 5'd1, 64'h111);
    step();
    set_wb(1'b1, 5'd11, 64'h11);
    set_mc(1'b1, 5'd2, 64'h222);
    step();
    check("starve_full", 64'(mc_ready), 64'd0);
    set_mc(1'b0, 5'd0, '0);
    set_wb(1'b1, 5'd12, 64'h12);
    step();
    check("starve_no_stall", 64'(pipe_stall), 64'd0);
    set_wb(1'b1, 5'd13, 64'h13);
    step();
    check("starve_stall1", 64'(pipe_stall), 64'd1);
    step();
    check("starve_pop1_we", 64'(rf_we), 64'd1);
    check("starve_pop1_addr", 64'(rf_waddr), 64'd1);
    check("starve_stall_release", 64'(pipe_stall), 64'd0);
    step();
    check("starve_held_wb", 64'(rf_waddr), 64'd13);
    set_wb(1'b1, 5'd14, 64'h14);
    step();
    set_wb(1'b1, 5'd15, 64'h15);
    step();
    check("starve_stall2", 64'(pipe_stall), 64'd1);
    step();
    check("starve_pop2_addr", 64'(rf_waddr), 64'd2);
    set_wb(1'b0, 5'd0, '0);
    step();

    // Register-zero suppression
    set_wb(1'b1, 5'd0, 64'hFF);
    step();
    check("rd0_wb_we", 64'(rf_we), 64'd0);
    set_wb(1'b0, 5'd0, '0);
    set_mc(1'b1, 5'd0, 64'hAA);
    step();
    step();
    check("rd0_full", 64'(mc_ready), 64'd0);
    set_mc(1'b0, 5'd0, '0);
    step();
    check("rd0_pop_we", 64'(rf_we), 64'd0);
    check("rd0_pop_ready", 64'(mc_ready), 64'd1);
    step();
    step();

    // Push and pop in the same cycle
    set_mc(1'b1, 5'd20, 64'h20);
    step();
    set_mc(1'b0, 5'd0, '0);
    step();
    set_mc(1'b1, 5'd21, 64'h21);
    step();
    check("pp_first_we", 64'(rf_we), 64'd1);
    check("pp_first_addr", 64'(rf_waddr), 64'd20);
    check("pp_ready", 64'(mc_ready), 64'd1);
    set_mc(1'b0, 5'd0, '0);
    step();
    check("pp_fresh_we", 64'(rf_we), 64'd0);
    step();
    check("pp_second_addr", 64'(rf_waddr), 64'd21);
    check("pp_second_we", 64'(rf_we), 64'd1);

    // Reset while the queue is full and the pipeline is stalled
    set_wb(1'b1, 5'd30, 64'h30);
    set_mc(1'b1, 5'd3, 64'h333);
    step();
    set_mc(1'b1, 5'd4, 64'h444);
    step();
    set_mc(1'b0, 5'd0, '0);
    step();
    step();
    check("midrst_stall_before", 64'(pipe_stall), 64'd1);
    pulse_reset();
    set_wb(1'b0, 5'd0, '0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_write", 64'(rf_we), 64'd0);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (!exp_stall) begin
        set_wb(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)),
               {$urandom, $urandom});
      end
      set_mc(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)),
             {$urandom, $urandom});
      step();
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

    set_wb(1'b0, 5'd0, '0);
    set_mc(1'b0, 5'd0, '0);
    for (int i = 0; i < 10; i++) step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 64, register-file write data width.
- FIFO_DEPTH, 2, multicycle-result queue entries (power of two, at least 2).
- STARVE_LIMIT, 3, consecutive non-granted cycles before the queue head is forced.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- wb_valid, in, 1, pipeline WB-stage write request (the WB RegWrite).
- wb_rd, in, 5, pipeline destination register.
- wb_data, in, DATA_W, pipeline write data (already MemToReg-selected).
- mc_valid, in, 1, multicycle (AES/SIMD) unit result valid.
- mc_rd, in, 5, multicycle destination register.
- mc_data, in, DATA_W, multicycle result data.
- mc_ready, out, 1, queue can accept a multicycle result.
- rf_we, out, 1, register-file write enable (registered).
- rf_waddr, out, 5, register-file write address (registered).
- rf_wdata, out, DATA_W, register-file write data (registered).
- pipe_stall, out, 1, pipeline must hold its WB stage this cycle.

Function
REQ-003 The block SHALL share the single register-file write port between the pipeline WB stage and a FIFO_DEPTH-entry queue of multicycle results.
REQ-004 The multicycle side SHALL handshake as follows:
- mc_ready = queue not full.
- A result is pushed when mc_valid && mc_ready.
- There is no bypass: a pushed result reaches rf_we no earlier than 2 cycles after acceptance.
REQ-005 Grant SHALL be decided each cycle from registered state as follows:
- FORCE (starve_cnt == STARVE_LIMIT and queue non-empty): grant the queue head and drive pipe_stall=1.
- Otherwise, if wb_valid: grant the pipeline, pipe_stall=0.
- Otherwise, if the queue is non-empty: grant the queue head.
- Otherwise: no grant.
REQ-006 pipe_stall SHALL be combinational from registered state only, and SHALL NOT depend on wb_valid.
REQ-007 While pipe_stall=1 the pipeline SHALL hold wb_* stable; the arbiter SHALL NOT consume the wb request that cycle.
REQ-008 starve_cnt SHALL behave as follows:
- Increments (saturating at STARVE_LIMIT) each cycle the queue is non-empty and the head is not granted.
- Clears on any queue pop.
- Clears when the queue is empty.
REQ-009 A granted request SHALL appear on rf_we/rf_waddr/rf_wdata on the next rising edge (1-cycle latency).
- With no grant, rf_we=0; rf_waddr and rf_wdata hold their previous values.
REQ-010 A granted request with rd==0 SHALL be consumed (popped or accepted) but SHALL produce rf_we=0.
REQ-011 Simultaneous push and pop in the same cycle SHALL be supported:
- Occupancy is unchanged.
- Order stays FIFO.
- When the queue is full, mc_ready=0, so no push occurs even if a pop happens that cycle.
REQ-012 Queue read/write pointers SHALL wrap modulo FIFO_DEPTH.
- Occupancy is tracked in a counter of width clog2(FIFO_DEPTH)+1.
REQ-013 The block SHALL NOT reorder or check ordering between pipeline and queue writes to the same rd: the later rf_we wins.

Reset
REQ-014 On rst_n=0 the block SHALL asynchronously clear all state and outputs:
- Queue emptied, pointers cleared, starve_cnt=0.
- rf_we=0, rf_waddr=0, rf_wdata=0.
- mc_ready=1, pipe_stall=0.
REQ-015 Reset asserted mid-operation SHALL discard all queued results without writing them.
REQ-016 After rst_n deasserts, the first grant SHALL occur on the first rising edge with a valid request.

Verification
REQ-017 Lone pipeline write: wb_valid=1, wb_rd=5, wb_data=0xA5 for 1 cycle -> next edge rf_we=1, rf_waddr=5, rf_wdata=0xA5; the following cycle rf_we=0.
REQ-018 Lone multicycle write: mc_valid=1, mc_rd=7, mc_data=0x1234 accepted at edge N -> rf_we=1, rf_waddr=7 after edge N+2; mc_ready stays 1.
REQ-019 Queue fill and starvation:
- Stimulus: wb_valid=1 continuously; push mc results rd=1, rd=2.
- mc_ready=0 after the second push.
- After 3 non-granted cycles, pipe_stall=1 for one cycle and rd=1 is written.
- The held wb request is written on the next grant.
- rd=2 is forced after a further 3 cycles.
REQ-020 Register-zero suppression: wb_valid=1, wb_rd=0, wb_data=0xFF -> rf_we stays 0; mc_rd=0 entry is popped (occupancy decreases) with rf_we=0.
REQ-021 Reset mid-operation:
- Stimulus: queue holding 2 entries and pipe_stall=1, then rst_n pulsed low between edges.
- Immediately: rf_we=0, pipe_stall=0, mc_ready=1.
- Afterwards: no queued entry is ever written.
REQ-022 Push/pop same cycle: queue holds 1 entry with wb_valid=0, plus mc_valid=1 -> head written, new entry queued, occupancy stays 1, and write order matches push order.
